avg_frame_sequencer: RTL and testbench
======================================

Name: avg_frame_sequencer

Overview:
Frame-level controller for the 2x2 averaging datapath. It captures one row-major frame of ROWS x COLS 8-bit pixels into an internal buffer (LOAD). It then walks every 2x2 window with a single-read-per-cycle buffer port, accumulating and emitting one averaged byte per window (CALC). Afterwards it re-arms for the next frame. It sits between the pixel stream source and the result consumer, and gates input with busy.

Parameters:
ROWS, 16, frame height in rows (>=2)
COLS, 8, frame width in pixels per row (>=2)
DW, 8, pixel and result width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  data is a pixel this cycle
data  input  DW  pixel, row-major order (col fastest)
busy  output  1  high in CALC; in_valid ignored while high
valid  output  1  one-cycle pulse, out holds a window result
out  output  DW  floor(sum of 4 window pixels / 4)
win_row  output  4  row index r of the window on out (0..ROWS-2)
win_col  output  3  col index c of the window on out (0..COLS-2)
done  output  1  one-cycle pulse coincident with the last valid of a frame

Behaviour:
- Reset (sync, active-high, wins over everything): state=LOAD; pixel counter, window r/c and step counters=0; accumulator=0; busy=0, valid=0, out=0, win_row=0, win_col=0, done=0. Buffer contents are don't-care.
- LOAD:
  - Each cycle with in_valid=1, store data at buffer[cnt] and increment cnt. Gaps (in_valid=0) are allowed and hold state.
  - On the cycle the ROWS*COLS-th pixel is accepted, next state=CALC and cnt clears. busy rises the following cycle.
- CALC:
  - busy=1; in_valid/data ignored and never written into the buffer.
  - Each window (r,c) takes 4 cycles, steps 0..3. Reads occur in this order: (r,c), (r,c+1), (r+1,c), (r+1,c+1).
  - Step 0 loads the accumulator with the pixel; steps 1-3 add to it.
  - Accumulator is DW+2 bits (max 1020, no overflow).
  - After step 3: out <= acc_final[DW+1:2] (truncate, no rounding), win_row/win_col <= r/c, valid <= 1 for exactly one cycle.
  - Window order is row-major: c increments 0..COLS-2; at wrap c=0 and r increments.
- Timing: with T = first CALC cycle, valid is high at T+4, T+8, ..., T+4*W, where W=(ROWS-1)*(COLS-1)=105 by default.
- Completion: after step 3 of window (ROWS-2, COLS-2), next state=LOAD and busy=0 in that same cycle.
  - The final valid and done pulse together in that first LOAD cycle.
  - A pixel presented in that cycle is accepted as pixel 0 of the next frame (no dead cycle).
- out, win_row and win_col hold their last values between valid pulses.
- Reset mid-LOAD or mid-CALC: the partial frame is abandoned and no further valid/done is issued for it. The block restarts in LOAD with cnt=0.

Test Plan:
- Ramp frame (pixel i = i, 0..127), continuous in_valid -> 105 valid pulses 4 cycles apart. out = 8r+c+4 (first 4 at r=0,c=0; last 122 at r=14,c=6); done with the last pulse only; busy high 420 cycles.
- All-255 frame -> every out=255 (sum 1020, no wrap); all-0 frame -> every out=0.
- Rows alternate 0/3 (row 2k=0, row 2k+1=3) -> sum 6 per window -> out=1 (truncation check).
- Ramp frame with random in_valid gaps; in_valid=1 with data=0xAA throughout CALC -> results identical to the gapless ramp run, no buffer corruption.
- Back-to-back frames: frame 2 (ramp+1) first pixel driven in the done cycle -> accepted; frame 2 results = frame 1 results + 1.
- Assert reset at CALC window 50, then load a fresh ramp frame -> all outputs 0 during and after reset; no stale valid; next frame reproduces the ramp results exactly.

Source files
------------

// File: rtl/avg_frame_sequencer.sv
// rtl/avg_frame_sequencer.sv - frame loader and 2x2 window averaging sequencer
module avg_frame_sequencer #(
    parameter int ROWS = 16,
    parameter int COLS = 8,
    parameter int DW   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DW-1:0]             data,
    output logic                      busy,
    output logic                      valid,
    output logic [DW-1:0]             out,
    output logic [$clog2(ROWS)-1:0]   win_row,
    output logic [$clog2(COLS)-1:0]   win_col,
    output logic                      done
);

    localparam int NPIX = ROWS * COLS;
    localparam int AW   = $clog2(NPIX);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    typedef enum logic {
        LOAD = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [DW-1:0]   mem [NPIX];
    logic [AW-1:0]   cnt;
    logic [RW-1:0]   r;
    logic [CW-1:0]   c;
    logic [1:0]      step;
    logic [DW+1:0]   acc;
    logic [DW+1:0]   acc_sum;
    logic [DW-1:0]   rd_pix;
    logic [AW-1:0]   rd_addr;
    logic            last_pix;
    logic            last_col;
    logic            last_win;

    // step[0] selects the right-hand column, step[1] the lower row of the window
    assign rd_addr  = AW'((int'(r) + int'(step[1])) * COLS + int'(c) + int'(step[0]));
    assign rd_pix   = mem[rd_addr];
    assign acc_sum  = (step == 2'd0) ? {2'b00, rd_pix} : acc + {2'b00, rd_pix};
    assign last_pix = (cnt == AW'(NPIX - 1));
    assign last_col = (c == CW'(COLS - 2));
    assign last_win = last_col && (r == RW'(ROWS - 2)) && (step == 2'd3);
    assign busy     = (state_q == CALC);

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: LOAD until the frame is full, CALC until the last window retires
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (in_valid && last_pix) state_d = CALC;
            CALC: if (last_win)             state_d = LOAD;
        endcase
    end

    // frame buffer write port, open only while loading
    always_ff @(posedge clk) begin
        if (!reset && state_q == LOAD && in_valid) begin
            mem[cnt] <= data;
        end
    end

    // pixel counter, window walk, accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            r       <= '0;
            c       <= '0;
            step    <= '0;
            acc     <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            win_row <= '0;
            win_col <= '0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            if (state_q == LOAD) begin
                if (in_valid) begin
                    cnt <= last_pix ? '0 : cnt + AW'(1);
                end
            end else begin
                acc  <= acc_sum;
                step <= step + 2'd1;
                if (step == 2'd3) begin
                    out     <= acc_sum[DW+1:2];
                    win_row <= r;
                    win_col <= c;
                    valid   <= 1'b1;
                    done    <= last_win;
                    if (last_col) begin
                        c <= '0;
                        r <= last_win ? '0 : r + RW'(1);
                    end else begin
                        c <= c + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_avg_frame_sequencer.sv
// tb/tb_avg_frame_sequencer.sv - self-checking bench for avg_frame_sequencer
module tb_avg_frame_sequencer;

    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int NPIX = ROWS * COLS;
    localparam int W    = (ROWS - 1) * (COLS - 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] data;
    logic          busy;
    logic          valid;
    logic [DW-1:0] out;
    logic [3:0]    win_row;
    logic [2:0]    win_col;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;
    int frame [NPIX];
    int rnd   [NPIX];

    typedef struct {
        int kind;
        int gap_pct;
        bit garbage;
        int idle_after;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t tbl [8];

    avg_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .data     (data),
        .busy     (busy),
        .valid    (valid),
        .out      (out),
        .win_row  (win_row),
        .win_col  (win_col),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix_of(input int kind, input int i);
        case (kind)
            0:       return i;
            1:       return 255;
            2:       return 0;
            3:       return ((i / COLS) % 2 == 1) ? 3 : 0;
            4:       return i + 1;
            default: return rnd[i];
        endcase
    endfunction

    function automatic void fill_frame(input int kind);
        for (int i = 0; i < NPIX; i++) frame[i] = pix_of(kind, i);
    endfunction

    // entered at a negedge; leaves at the negedge of the first CALC cycle
    task automatic load_frame(input int gap_pct);
        int i = 0;
        int tries = 0;
        while (i < NPIX) begin
            if (tries < 4 * NPIX && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                data     = 8'($urandom_range(0, 255));
            end else begin
                in_valid = 1'b1;
                data     = 8'(frame[i]);
                i++;
            end
            tries++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // entered at negedge of first CALC cycle; leaves at negedge of the done cycle
    task automatic check_calc(input bit garbage, output int nval, output int first_o,
                              output int last_o, output int busy_cyc);
        int eo [W];
        int er [W];
        int ec [W];
        int k = 0;
        int cyc = 0;
        bit fin = 1'b0;
        for (int rr = 0; rr < ROWS - 1; rr++) begin
            for (int cc = 0; cc < COLS - 1; cc++) begin
                eo[rr * (COLS - 1) + cc] = (frame[rr * COLS + cc] + frame[rr * COLS + cc + 1] +
                                            frame[(rr + 1) * COLS + cc] +
                                            frame[(rr + 1) * COLS + cc + 1]) / 4;
                er[rr * (COLS - 1) + cc] = rr;
                ec[rr * (COLS - 1) + cc] = cc;
            end
        end
        first_o  = -1;
        last_o   = -1;
        busy_cyc = 0;
        chk("busy_first_calc", int'(busy), 1);
        if (garbage) begin
            in_valid = 1'b1;
            data     = 8'hAA;
        end
        while (!fin && cyc < 4 * W + 16) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
            if (valid) begin
                if (k < W) begin
                    chk("out", int'(out), eo[k]);
                    chk("win_row", int'(win_row), er[k]);
                    chk("win_col", int'(win_col), ec[k]);
                    chk("valid_cycle", cyc, 4 * (k + 1));
                    chk("done_at_valid", int'(done), (k == W - 1) ? 1 : 0);
                    if (k == 0) first_o = int'(out);
                    last_o = int'(out);
                end
                k++;
                if (done || k >= W) fin = 1'b1;
            end else begin
                chk("done_quiet", int'(done), 0);
                if (k > 0) chk("out_hold", int'(out), eo[k - 1]);
            end
        end
        if (!fin) chk("calc_timeout", 0, 1);
        chk("busy_done_cycle", int'(busy), 0);
        in_valid = 1'b0;
        nval = k;
    endtask

    initial begin
        int nv;
        int fo;
        int lo;
        int bc;
        int cyc;

        reset    = 1'b1;
        in_valid = 1'b0;
        data     = '0;
        for (int i = 0; i < NPIX; i++) rnd[i] = $urandom_range(0, 255);

        tbl[0] = '{kind: 0, gap_pct: 0,  garbage: 0, idle_after: 3, exp_first: 4,   exp_last: 122};
        tbl[1] = '{kind: 1, gap_pct: 0,  garbage: 0, idle_after: 2, exp_first: 255, exp_last: 255};
        tbl[2] = '{kind: 2, gap_pct: 0,  garbage: 0, idle_after: 2, exp_first: 0,   exp_last: 0};
        tbl[3] = '{kind: 3, gap_pct: 0,  garbage: 0, idle_after: 2, exp_first: 1,   exp_last: 1};
        tbl[4] = '{kind: 0, gap_pct: 30, garbage: 1, idle_after: 2, exp_first: 4,   exp_last: 122};
        tbl[5] = '{kind: 0, gap_pct: 0,  garbage: 0, idle_after: 0, exp_first: 4,   exp_last: 122};
        tbl[6] = '{kind: 4, gap_pct: 0,  garbage: 1, idle_after: 2, exp_first: 5,   exp_last: 123};
        tbl[7] = '{kind: 5, gap_pct: 20, garbage: 1, idle_after: 2, exp_first: -1,  exp_last: -1};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_win_row", int'(win_row), 0);
        chk("rst_win_col", int'(win_col), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            fill_frame(tbl[v].kind);
            load_frame(tbl[v].gap_pct);
            check_calc(tbl[v].garbage, nv, fo, lo, bc);
            chk($sformatf("v%0d_nvalid", v), nv, W);
            chk($sformatf("v%0d_busy_cycles", v), bc, 4 * W);
            if (tbl[v].exp_first >= 0) begin
                chk($sformatf("v%0d_first", v), fo, tbl[v].exp_first);
                chk($sformatf("v%0d_last", v), lo, tbl[v].exp_last);
            end
            repeat (tbl[v].idle_after) @(negedge clk);
        end

        // abandon a partially loaded frame
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            data     = 8'd77;
            @(negedge clk);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("load_rst_busy", int'(busy), 0);
        reset = 1'b0;

        // abandon a frame in the middle of CALC
        fill_frame(0);
        load_frame(0);
        nv  = 0;
        cyc = 0;
        while (nv < 51 && cyc < 4 * W + 16) begin
            @(negedge clk);
            cyc++;
            if (valid) nv++;
        end
        chk("reach_window_50", nv, 51);
        reset    = 1'b1;
        in_valid = 1'b1;
        data     = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_valid", int'(valid), 0);
            chk("midrst_out", int'(out), 0);
            chk("midrst_win_row", int'(win_row), 0);
            chk("midrst_win_col", int'(win_col), 0);
            chk("midrst_done", int'(done), 0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_valid", int'(valid), 0);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_out", int'(out), 0);
        end
        fill_frame(0);
        load_frame(0);
        check_calc(1'b0, nv, fo, lo, bc);
        chk("after_rst_nvalid", nv, W);
        chk("after_rst_first", fo, 4);
        chk("after_rst_last", lo, 122);
        chk("after_rst_busy_cycles", bc, 4 * W);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
